// File: rtl/rob_pkg.sv
// Shared constants for the reorder buffer and its commit notification bundle.
package rob_pkg;
    localparam int PC_W   = 32;
    localparam int AREG_W = 5;

    // Keep a destination field only when the instruction writes a register.
    function automatic logic [AREG_W-1:0] areg_if_wen(input logic wen, input logic [AREG_W-1:0] areg);
        return wen ? areg : '0;
    endfunction
endpackage

// File: rtl/commit_notif.sv
// Commit notification bundle published by the reorder buffer (pub side) and
// consumed by the rename table's free list (sub side).
interface CommitNotif #(
    parameter int p_phys_addr_bits = 6,
    parameter int p_seq_num_bits   = 5
);
    import rob_pkg::*;

    logic                        val;
    logic [PC_W-1:0]             pc;
    logic [p_seq_num_bits-1:0]   seq_num;
    logic [AREG_W-1:0]           waddr;
    logic [p_phys_addr_bits-1:0] preg;
    logic [p_phys_addr_bits-1:0] ppreg;
    logic                        wen;

    modport pub (output val, pc, seq_num, waddr, preg, ppreg, wen);
    modport sub (input  val, pc, seq_num, waddr, preg, ppreg, wen);
endinterface

// File: rtl/wrap_ptr.sv
// Circular-buffer pointer: p_width index bits plus a phase bit in the MSB.
// The depth is a power of two, so plain binary increment wraps the index to 0
// and toggles the phase bit in one step.
module wrap_ptr #(
    parameter int p_width = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [p_width:0] ptr
);
    localparam logic [p_width:0] ONE = {{p_width{1'b0}}, 1'b1};

    // Pointer register: cleared by reset, advanced by one when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ONE;
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// In-order commit buffer. Decode allocates at the tail, writeback marks
// entries done by sequence number, and the head retires one entry per cycle
// on the commit bundle.
// Optional feature macro: ROB_COMPLETE_BYPASS_EN -- a completion that targets
// the current head entry commits it in the same cycle.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int p_depth          = 32,
    parameter int p_num_phys_regs  = 36,
    parameter int p_phys_addr_bits = $clog2(p_num_phys_regs),
    parameter int p_seq_num_bits   = $clog2(p_depth)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PC_W-1:0]             alloc_pc,
    input  logic [AREG_W-1:0]           alloc_areg,
    input  logic [p_phys_addr_bits-1:0] alloc_preg,
    input  logic [p_phys_addr_bits-1:0] alloc_ppreg,
    input  logic                        alloc_wen,
    input  logic                        alloc_en,
    output logic                        alloc_rdy,
    output logic [p_seq_num_bits-1:0]   alloc_seq_num,
    input  logic                        complete_val,
    input  logic [p_seq_num_bits-1:0]   complete_seq_num,
    CommitNotif.pub                     commit,
    output logic                        empty
);
    typedef struct packed {
        logic [PC_W-1:0]             pc;
        logic [AREG_W-1:0]           areg;
        logic [p_phys_addr_bits-1:0] preg;
        logic [p_phys_addr_bits-1:0] ppreg;
        logic                        wen;
    } rob_entry_t;

    localparam int ENTRY_W = $bits(rob_entry_t);

    logic [p_seq_num_bits:0]   head;
    logic [p_seq_num_bits:0]   tail;
    logic [p_seq_num_bits-1:0] head_idx;
    logic [p_seq_num_bits-1:0] tail_idx;
    logic                      full;
    logic                      alloc_fire;
    logic                      commit_fire;
    logic                      bypass_hit;
    logic                      head_valid;
    logic                      head_done;
    logic [p_depth-1:0]        valid;
    logic [p_depth-1:0]        done;
    logic [p_depth-1:0]        head_sel;
    logic [ENTRY_W-1:0]        head_bits;
    rob_entry_t                head_entry;
    rob_entry_t                mem [p_depth];

    wrap_ptr #(.p_width(p_seq_num_bits)) u_head_ptr (
        .clk (clk),
        .rst (rst),
        .inc (commit_fire),
        .ptr (head)
    );

    wrap_ptr #(.p_width(p_seq_num_bits)) u_tail_ptr (
        .clk (clk),
        .rst (rst),
        .inc (alloc_fire),
        .ptr (tail)
    );

    assign head_idx = head[p_seq_num_bits-1:0];
    assign tail_idx = tail[p_seq_num_bits-1:0];

    assign empty = (head == tail);
    assign full  = (head_idx == tail_idx) && (head[p_seq_num_bits] != tail[p_seq_num_bits]);

    // A same-cycle commit never frees a slot for this cycle's allocation:
    // readiness comes only from registered pointers.
    assign alloc_rdy     = !full;
    assign alloc_seq_num = tail_idx;
    assign alloc_fire    = alloc_en && alloc_rdy;

    // One-hot head decode and AND-OR select of the head entry, keeping
    // dynamic array indexing off the commit output path.
    always_comb begin
        head_sel  = '0;
        head_bits = '0;
        for (int i = 0; i < p_depth; i++) begin
            head_sel[i] = (int'(head_idx) == i);
            head_bits   = head_bits | ({ENTRY_W{head_sel[i]}} & mem[i]);
        end
    end

    assign head_entry = rob_entry_t'(head_bits);
    assign head_valid = |(head_sel & valid);
    assign head_done  = |(head_sel & done);

`ifdef ROB_COMPLETE_BYPASS_EN
    assign bypass_hit = complete_val && (complete_seq_num == head_idx) && head_valid && !head_done;
`else
    assign bypass_hit = 1'b0;
`endif

    // Nothing is published in a reset cycle, even if the head was ready.
    assign commit_fire = !rst && head_valid && (head_done || bypass_hit);

    // Every field reads zero when not committing; a non-writing instruction
    // reports register 0, which is never in the free list.
    assign commit.val     = commit_fire;
    assign commit.pc      = commit_fire ? head_entry.pc : '0;
    assign commit.seq_num = commit_fire ? head_idx : '0;
    assign commit.wen     = commit_fire && head_entry.wen;
    assign commit.waddr   = commit_fire ? areg_if_wen(head_entry.wen, head_entry.areg) : '0;
    assign commit.preg    = (commit_fire && head_entry.wen) ? head_entry.preg : '0;
    assign commit.ppreg   = (commit_fire && head_entry.wen) ? head_entry.ppreg : '0;

    // Entry status: completion sets done, commit retires the head, allocation
    // claims the tail. Allocation and commit never hit the same slot because
    // allocation requires the buffer not to be full.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            done  <= '0;
        end else begin
            for (int i = 0; i < p_depth; i++) begin
                if (complete_val && int'(complete_seq_num) == i) begin
                    done[i] <= 1'b1;
                end
                if (commit_fire && head_sel[i]) begin
                    valid[i] <= 1'b0;
                    done[i]  <= 1'b0;
                end
                if (alloc_fire && int'(tail_idx) == i) begin
                    valid[i] <= 1'b1;
                    done[i]  <= 1'b0;
                end
            end
        end
    end

    // Entry payload: written on allocation only, never reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            mem[tail_idx] <= '{pc: alloc_pc, areg: alloc_areg, preg: alloc_preg,
                               ppreg: alloc_ppreg, wen: alloc_wen};
        end
    end

`ifndef SYNTHESIS
    // Flag completions of entries that are not in flight or already done.
    always_ff @(posedge clk) begin
        if (!rst && complete_val && (!valid[complete_seq_num] || done[complete_seq_num])) begin
            $error("reorder_buffer: completion of invalid or already-done entry %0d", complete_seq_num);
        end
    end

    function automatic string trace(int level);
        string s;
        s = $sformatf("%2d:%2d", head_idx, tail_idx);
        if (level > 0) begin
            if (commit_fire) begin
                s = {s, $sformatf(" c%2d", head_idx)};
            end else begin
                s = {s, "    "};
            end
        end
        return s;
    endfunction
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-level reference model compared against the
// DUT every cycle, directed scenarios with literal expectations, then random
// allocate/complete/reset traffic.
module tb_reorder_buffer;
    localparam int DEPTH  = 32;
    localparam int SEQ_W  = 5;
    localparam int PHYS_W = 6;
`ifdef ROB_COMPLETE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       alloc_pc;
    logic [4:0]        alloc_areg;
    logic [PHYS_W-1:0] alloc_preg;
    logic [PHYS_W-1:0] alloc_ppreg;
    logic              alloc_wen;
    logic              alloc_en;
    logic              alloc_rdy;
    logic [SEQ_W-1:0]  alloc_seq_num;
    logic              complete_val;
    logic [SEQ_W-1:0]  complete_seq_num;
    logic              empty;

    CommitNotif #(.p_phys_addr_bits(PHYS_W), .p_seq_num_bits(SEQ_W)) cn ();

    reorder_buffer #(.p_depth(DEPTH), .p_num_phys_regs(36)) dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_pc         (alloc_pc),
        .alloc_areg       (alloc_areg),
        .alloc_preg       (alloc_preg),
        .alloc_ppreg      (alloc_ppreg),
        .alloc_wen        (alloc_wen),
        .alloc_en         (alloc_en),
        .alloc_rdy        (alloc_rdy),
        .alloc_seq_num    (alloc_seq_num),
        .complete_val     (complete_val),
        .complete_seq_num (complete_seq_num),
        .commit           (cn),
        .empty            (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                seq;
        logic [31:0]       pc;
        logic [4:0]        areg;
        logic [PHYS_W-1:0] preg;
        logic [PHYS_W-1:0] ppreg;
        logic              wen;
        bit                done;
    } ment_t;

    ment_t q[$];          // in-flight instructions in program order
    int    alloc_total;   // allocations since reset
    int    errors = 0;
    int    checks = 0;

    logic              obs_val, obs_rdy, obs_empty, obs_wen;
    logic [SEQ_W-1:0]  obs_seq, obs_aseq;
    logic [4:0]        obs_waddr;
    logic [PHYS_W-1:0] obs_preg, obs_ppreg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the queue model and current inputs.
    task automatic check_outputs();
        bit    e_val;
        ment_t h;
        e_val = 1'b0;
        h = '{seq: 0, pc: '0, areg: '0, preg: '0, ppreg: '0, wen: 1'b0, done: 1'b0};
        if (!rst && q.size() > 0) begin
            h = q[0];
            e_val = h.done || (BYP && complete_val && int'(complete_seq_num) == h.seq);
        end
        obs_val = cn.val;     obs_seq = cn.seq_num;  obs_wen = cn.wen;
        obs_waddr = cn.waddr; obs_preg = cn.preg;    obs_ppreg = cn.ppreg;
        obs_rdy = alloc_rdy;  obs_aseq = alloc_seq_num; obs_empty = empty;
        chk("commit_val", 32'(cn.val), 32'(e_val));
        chk("commit_pc", cn.pc, e_val ? h.pc : 32'd0);
        chk("commit_seq", 32'(cn.seq_num), e_val ? h.seq : 0);
        chk("commit_wen", 32'(cn.wen), 32'(e_val && h.wen));
        chk("commit_waddr", 32'(cn.waddr), (e_val && h.wen) ? 32'(h.areg) : 32'd0);
        chk("commit_preg", 32'(cn.preg), (e_val && h.wen) ? 32'(h.preg) : 32'd0);
        chk("commit_ppreg", 32'(cn.ppreg), (e_val && h.wen) ? 32'(h.ppreg) : 32'd0);
        chk("alloc_rdy", 32'(alloc_rdy), 32'(q.size() < DEPTH));
        chk("alloc_seq_num", 32'(alloc_seq_num), alloc_total % DEPTH);
        chk("empty", 32'(empty), 32'(q.size() == 0));
    endtask

    // Advance the model across one clock edge using the inputs held there.
    task automatic model_edge();
        bit    do_commit;
        int    pre_size;
        ment_t t;
        if (rst) begin
            q.delete();
            alloc_total = 0;
        end else begin
            pre_size  = q.size();
            do_commit = pre_size > 0 &&
                        (q[0].done || (BYP && complete_val && int'(complete_seq_num) == q[0].seq));
            if (complete_val) begin
                for (int k = 0; k < q.size(); k++) begin
                    if (q[k].seq == int'(complete_seq_num)) begin
                        t = q[k];
                        t.done = 1'b1;
                        q[k] = t;
                    end
                end
            end
            if (do_commit) void'(q.pop_front());
            if (alloc_en && pre_size < DEPTH) begin
                q.push_back('{seq: alloc_total % DEPTH, pc: alloc_pc, areg: alloc_areg,
                              preg: alloc_preg, ppreg: alloc_ppreg, wen: alloc_wen, done: 1'b0});
                alloc_total++;
            end
        end
    endtask

    task automatic step(input bit a_en, input logic [4:0] areg, input logic [PHYS_W-1:0] preg,
                        input logic [PHYS_W-1:0] ppreg, input bit wen, input bit c_val,
                        input logic [SEQ_W-1:0] c_seq, input bit r);
        alloc_en = a_en; alloc_areg = areg; alloc_preg = preg; alloc_ppreg = ppreg;
        alloc_wen = wen; alloc_pc = $urandom; complete_val = c_val;
        complete_seq_num = c_seq; rst = r;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 5'd0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic alloc(input logic [4:0] areg, input logic [PHYS_W-1:0] preg,
                         input logic [PHYS_W-1:0] ppreg, input bit wen);
        step(1'b1, areg, preg, ppreg, wen, 1'b0, '0, 1'b0);
    endtask

    task automatic complete(input logic [SEQ_W-1:0] s);
        step(1'b0, 5'd0, '0, '0, 1'b0, 1'b1, s, 1'b0);
    endtask

    initial begin
        int first, ncommit, rdy_k, prev_seq, wraps, bad_order, cseq[$];
        logic [4:0] cap_waddr;
        logic [PHYS_W-1:0] cap_preg, cap_ppreg;
        logic cap_wen;

        rst = 1'b1; alloc_en = 0; alloc_pc = 0; alloc_areg = 0; alloc_preg = 0;
        alloc_ppreg = 0; alloc_wen = 0; complete_val = 0; complete_seq_num = 0;
        alloc_total = 0;
        repeat (2) @(negedge clk);

        // Reset state.
        do_reset();
        idle();
        chk("rst_rdy", 32'(obs_rdy), 32'd1);
        chk("rst_empty", 32'(obs_empty), 32'd1);
        chk("rst_aseq", 32'(obs_aseq), 32'd0);
        chk("rst_val", 32'(obs_val), 32'd0);

        // Single instruction: alloc, complete, commit.
        alloc(5'd5, 6'd32, 6'd5, 1'b1);
        first = -1; cap_waddr = 0; cap_preg = 0; cap_ppreg = 0; cseq.delete();
        for (int k = 0; k < 4; k++) begin
            if (k == 0) complete(5'd0); else idle();
            if (obs_val && first < 0) begin
                first = k; cseq.push_back(int'(obs_seq));
                cap_waddr = obs_waddr; cap_preg = obs_preg; cap_ppreg = obs_ppreg;
            end
        end
        chk("t1_commit_cycle", first, BYP ? 0 : 1);
        chk("t1_seq", (cseq.size() > 0) ? cseq[0] : -1, 0);
        chk("t1_waddr", 32'(cap_waddr), 32'd5);
        chk("t1_preg", 32'(cap_preg), 32'd32);
        chk("t1_ppreg", 32'(cap_ppreg), 32'd5);
        chk("t1_empty", 32'(obs_empty), 32'd1);

        // Out-of-order completion, in-order commit.
        do_reset();
        for (int k = 0; k < 3; k++) alloc(5'(k + 1), 6'(10 + k), 6'(k + 1), 1'b1);
        complete(5'd2);
        chk("t2_nocommit_a", 32'(obs_val), 32'd0);
        complete(5'd1);
        chk("t2_nocommit_b", 32'(obs_val), 32'd0);
        first = -1; cseq.delete();
        for (int k = 0; k < 6; k++) begin
            if (k == 0) complete(5'd0); else idle();
            if (obs_val) begin
                if (first < 0) first = k;
                cseq.push_back(int'(obs_seq));
            end
        end
        chk("t2_first", first, BYP ? 0 : 1);
        chk("t2_count", cseq.size(), 3);
        for (int k = 0; k < cseq.size(); k++) chk("t2_order", cseq[k], k);

        // Fill, then commit one and refill with the wrapped sequence number.
        do_reset();
        for (int k = 0; k < DEPTH; k++) alloc(5'(k % 31 + 1), 6'(k), 6'(k + 1), 1'b1);
        alloc(5'd1, 6'd1, 6'd1, 1'b1);
        chk("t3_full_rdy", 32'(obs_rdy), 32'd0);
        chk("t3_full_empty", 32'(obs_empty), 32'd0);
        first = -1; rdy_k = -1;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 5'd3, 6'd7, 6'd8, 1'b1, k == 0, 5'd0, 1'b0);
            if (obs_val && first < 0) first = k;
            if (k == rdy_k + 1 && rdy_k >= 0) chk("t3_refull", 32'(obs_rdy), 32'd0);
            if (obs_rdy && rdy_k < 0) begin
                rdy_k = k;
                chk("t3_wrap_aseq", 32'(obs_aseq), 32'd0);
            end
        end
        chk("t3_rdy_after_commit", rdy_k - first, 1);

        // Non-writing instruction frees nothing.
        do_reset();
        alloc(5'd7, 6'd9, 6'd11, 1'b0);
        first = -1; cap_wen = 1; cap_waddr = '1; cap_preg = '1; cap_ppreg = '1;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) complete(5'd0); else idle();
            if (obs_val && first < 0) begin
                first = k; cap_wen = obs_wen; cap_waddr = obs_waddr;
                cap_preg = obs_preg; cap_ppreg = obs_ppreg;
            end
        end
        chk("t4_seen", 32'(first >= 0), 32'd1);
        chk("t4_wen", 32'(cap_wen), 32'd0);
        chk("t4_waddr", 32'(cap_waddr), 32'd0);
        chk("t4_preg", 32'(cap_preg), 32'd0);
        chk("t4_ppreg", 32'(cap_ppreg), 32'd0);

        // Steady stream with a one-entry backlog across the index wrap.
        do_reset();
        alloc(5'd1, 6'd1, 6'd2, 1'b1);
        ncommit = 0; prev_seq = -1; wraps = 0; bad_order = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 5'($urandom_range(1, 31)), 6'($urandom_range(0, 35)),
                 6'($urandom_range(0, 35)), 1'b1, 1'b1, 5'(k % DEPTH), 1'b0);
            if (obs_val) begin
                if (prev_seq >= 0 && int'(obs_seq) != (prev_seq + 1) % DEPTH) bad_order++;
                if (prev_seq == DEPTH - 1 && obs_seq == 0) wraps++;
                prev_seq = int'(obs_seq);
                ncommit++;
            end
        end
        chk("t5_commits", ncommit, BYP ? 40 : 39);
        chk("t5_order_breaks", bad_order, 0);
        chk("t5_wraps", wraps, 1);

        // Reset with live entries, one of them ready to commit.
        do_reset();
        for (int k = 0; k < 3; k++) alloc(5'(k + 2), 6'(k + 3), 6'(k + 4), 1'b1);
        complete(5'd0);
        do_reset();
        chk("t6_rst_cycle_val", 32'(obs_val), 32'd0);
        idle();
        chk("t6_empty", 32'(obs_empty), 32'd1);
        chk("t6_aseq", 32'(obs_aseq), 32'd0);
        chk("t6_val", 32'(obs_val), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            bit a, c, r;
            logic [SEQ_W-1:0] cs;
            int cand[$];
            cand.delete();
            r  = ($urandom_range(0, 199) == 0);
            a  = ($urandom_range(0, 99) < ((n < 750) ? 75 : 45));
            c  = 1'b0;
            cs = '0;
            if (!r) begin
                for (int k = 0; k < q.size(); k++) if (!q[k].done) cand.push_back(k);
                if (cand.size() > 0 && $urandom_range(0, 99) < 55) begin
                    c  = 1'b1;
                    cs = SEQ_W'(q[cand[$urandom_range(0, cand.size() - 1)]].seq);
                end
            end
            step(a, 5'($urandom), 6'($urandom_range(0, 35)), 6'($urandom_range(0, 35)),
                 1'($urandom), c, cs, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order commit buffer that publishes the commit notifications consumed by the rename table's free list. Decode allocates one entry per renamed instruction with the destination's new and previous physical registers. Writeback marks entries done by sequence number. The head entry retires in program order, one per cycle, on `CommitNotif.pub`.

## Interface
- `p_depth`, 32, number of entries; power of two, ≥2
- `p_num_phys_regs`, 36, physical register count
- `p_phys_addr_bits`, `$clog2(p_num_phys_regs)`, physical register index width
- `p_seq_num_bits`, `$clog2(p_depth)`, sequence number width

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `alloc_pc` in 32: instruction PC
- `alloc_areg` in 5: architectural destination
- `alloc_preg` in `p_phys_addr_bits`: newly allocated physical register
- `alloc_ppreg` in `p_phys_addr_bits`: previous mapping, freed at commit
- `alloc_wen` in 1: instruction writes a register (`areg != 0`)
- `alloc_en` in 1: allocation request
- `alloc_rdy` out 1: entry available
- `alloc_seq_num` out `p_seq_num_bits`: index given to the allocating instruction (tail)
- `complete_val` in 1: writeback completion
- `complete_seq_num` in `p_seq_num_bits`: entry being completed
- `commit` `CommitNotif.pub`: drives `val`, `pc`, `seq_num`, `waddr`, `preg`, `ppreg`, `wen`
- `empty` out 1: no valid entries

## Operation
- Circular buffer: `head` and `tail` pointers are `p_seq_num_bits`+1 wide; the MSB is a phase bit.
  - `empty` = pointers equal.
  - `full` = low bits equal and phase bits differ.
- Each entry holds `valid`, `done`, `pc`, `areg`, `preg`, `ppreg`, `wen`.
- Allocation:
  - `alloc_rdy = !full`, from registered state only.
  - On `alloc_en & alloc_rdy`, the entry at `tail` is written with `valid=1`, `done=0`, and `tail` increments.
  - `alloc_seq_num = tail[p_seq_num_bits-1:0]` at all times.
- Completion:
  - `complete_val` sets `done` on entry `complete_seq_num`.
  - Completing an invalid or already-done entry is illegal; the simulation assertion fires (`$error`), and RTL behaviour is unspecified.
- Commit:
  - Commit happens when the head entry is `valid & done`.
  - `commit.val=1`; `seq_num=head`; other fields come from the entry.
  - If `wen=0`: `commit.waddr=0`, `commit.preg=0`, `commit.ppreg=0`. Index 0 is never in the free list, so nothing is freed.
  - The head entry is cleared (`valid=0`) and `head` increments. At most one commit per cycle.
- Simultaneous events:
  - Allocate and commit in the same cycle: both happen, and the count is unchanged.
  - When full, a same-cycle commit does not raise `alloc_rdy` until the next cycle.
  - Completion of entry X and allocation into entry X in the same cycle is impossible, because X must already be valid to complete.
- Pointer wrap: increment from `p_depth-1` returns the low bits to 0 and toggles the phase bit.

## Timing
- Reset values:
  - `head=tail=0`, all `valid=0`, all `done=0`.
  - `alloc_rdy=1`, `alloc_seq_num=0`, `empty=1`.
  - `commit.val=0`; all other `commit` fields 0.
- `rst` asserted mid-operation discards all entries on that edge. No commit is emitted in the reset cycle.
- `commit` fields are combinational from registered head state (plus bypass, below).
- Allocation-to-commit minimum latency:
  - allocate in cycle N, complete in N+1, commit visible in N+2 (baseline);
  - commit in N+1 with bypass enabled.
- `done` is set at the clock edge after `complete_val`.

## Configuration
- `ROB_COMPLETE_BYPASS_EN` defined:
  - if `complete_val` targets the current head entry (valid, not yet done), the commit is emitted in that same cycle and the head advances at that edge.
  - Adds a comparator from `complete_seq_num` into the `commit.val` path.
- Undefined: the entry commits no earlier than the cycle after completion.

## Structure
- Package `rob_pkg`: `rob_entry_t` packed struct, parameterised via a typedef inside the module or via package-level default widths.
- One sub-module: `wrap_ptr`, a pointer register with phase bit, increment enable and synchronous reset. It is instantiated for `head` and `tail`.
- Commit field muxing uses an AND-OR select over entries, with no unpacked-array dynamic indexing on the output path.
- A `trace(int level)` function under `ifndef SYNTHESIS`, fixed-width like the other decode/issue blocks.

## Test plan
- Reset, then allocate areg 5 / preg 32 / ppreg 5 / wen 1 at seq 0, then complete seq 0 -> commit `val=1`, `seq_num=0`, `waddr=5`, `ppreg=5` at N+2 (N+1 with bypass); `empty=1` afterwards.
- Allocate seqs 0,1,2; complete in order 2,1,0 -> no commit until 0 is done, then commits 0,1,2 on three consecutive cycles.
- Fill all 32 entries -> `alloc_rdy=0` after the 32nd. Complete seq 0 and assert `alloc_en` -> commit of 0, with `alloc_rdy` returning the cycle after. The next allocation gets seq 0 with the phase bit toggled.
- Allocate `wen=0` (store), complete it -> commit `val=1`, `wen=0`, `ppreg=0`, `preg=0`.
- Allocate and commit simultaneously for 40 cycles with a constant one-entry backlog -> seq numbers wrap 31→0 with no lost or duplicated commits.
- Assert `rst` with 3 valid entries -> next cycle `empty=1`, `alloc_seq_num=0`, `commit.val=0`.
